// File: rtl/pe_array_feeder_if.sv
// Operand vector stream into the systolic-array feeder: one (A-column, B-row) pair per beat.
// Latency: none, this is a wiring bundle.
// Backpressure: a beat transfers on a cycle where i_valid and o_ready are both high.
interface pe_array_feeder_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [N*WIDTH-1:0] i_a_vec;
    logic [N*WIDTH-1:0] i_b_vec;

    // Producer drives the vectors and valid; the feeder returns ready.
    modport master (output i_valid, output i_a_vec, output i_b_vec, input o_ready);
    modport slave  (input i_valid, input i_a_vec, input i_b_vec, output o_ready);
endinterface

// File: rtl/pe_array_feeder.sv
// Skewing operand feeder and job sequencer for an N x N output-stationary MAC array.
// Latency: lane k of an accepted beat reaches the array edge k+1 cycles later; o_done 2N cycles after last accept.
// Backpressure: o_ready only while beats remain in STREAM; stalls inject zero beats. Optional FEEDER_STALL_CNT_EN adds o_stall_cnt.
module pe_array_feeder #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int KW    = 16
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_start,
    input  logic [KW-1:0]      i_k,
    pe_array_feeder_if.slave   vec_if,
    output logic [N*WIDTH-1:0] o_a_lane,
    output logic [N*WIDTH-1:0] o_b_lane,
    output logic               o_doProcess,
    output logic               o_busy,
    output logic               o_done,
    input  logic               i_ack
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]        o_stall_cnt
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Drain must cover the deepest lane skew plus the diagonal walk to PE(N-1,N-1).
    localparam int         DW         = $clog2(2 * N);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(2 * N - 2);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] beats_q, beats_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          do_q;
    logic          ready;
    logic          accept;

    assign ready          = (state_q == ST_STREAM) && (beats_q != '0);
    assign accept         = vec_if.i_valid && ready;
    assign vec_if.o_ready = ready;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_done         = (state_q == ST_DONE);
    assign o_doProcess    = do_q;

    // Job sequencing: beat countdown while streaming, fixed-length drain, hold until acked.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    beats_d = i_k;
                    drain_d = DRAIN_INIT;
                    state_d = (i_k == '0) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == KW'(1)) begin
                        drain_d = DRAIN_INIT;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                // Ack wins over a simultaneous start; the start is simply dropped.
                if (i_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the array enable; enable follows next state so it drops the cycle after ack.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
            beats_q <= '0;
            drain_q <= '0;
            do_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            drain_q <= drain_d;
            do_q    <= (state_d != ST_IDLE);
        end
    end

    // Per-lane skew lines: lane k is k+1 registers deep so the array sees a diagonal wavefront.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [WIDTH-1:0] a_sk_q [k+1];
        logic [WIDTH-1:0] b_sk_q [k+1];
        logic [WIDTH-1:0] a_in_d;
        logic [WIDTH-1:0] b_in_d;

        // Anything but an accepted beat enters as zero so the MACs add nothing.
        assign a_in_d = accept ? vec_if.i_a_vec[k*WIDTH +: WIDTH] : '0;
        assign b_in_d = accept ? vec_if.i_b_vec[k*WIDTH +: WIDTH] : '0;

        // Shift the lane one stage per cycle, unconditionally, to keep lanes aligned across stalls.
        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                for (int s = 0; s <= k; s++) begin
                    a_sk_q[s] <= '0;
                    b_sk_q[s] <= '0;
                end
            end else begin
                a_sk_q[0] <= a_in_d;
                b_sk_q[0] <= b_in_d;
                for (int s = 1; s <= k; s++) begin
                    a_sk_q[s] <= a_sk_q[s-1];
                    b_sk_q[s] <= b_sk_q[s-1];
                end
            end
        end

        assign o_a_lane[k*WIDTH +: WIDTH] = a_sk_q[k];
        assign o_b_lane[k*WIDTH +: WIDTH] = b_sk_q[k];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count streaming cycles that moved no beat; cleared by a new job, held after streaming ends.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            stall_q <= '0;
        end else if ((state_q == ST_STREAM) && !accept && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder with a behavioural 4x4 output-stationary MAC array on the lanes.
// Latency: checks skew timing, 2N-cycle completion and enable release after ack.
// Backpressure: exercises a valid gap (zero injection) and the i_k==0 no-beat job.
module tb_pe_array_feeder;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          ack = 1'b0;
    logic [N*W-1:0] a_lane, b_lane;
    logic          do_proc, busy, done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    pe_array_feeder_if #(.N(N), .WIDTH(W)) vif ();

    pe_array_feeder #(.N(N), .WIDTH(W), .KW(KW)) dut (
        .i_clk       (clk),
        .i_arst_n    (arst_n),
        .i_start     (start),
        .i_k         (k_len),
        .vec_if      (vif),
        .o_a_lane    (a_lane),
        .o_b_lane    (b_lane),
        .o_doProcess (do_proc),
        .o_busy      (busy),
        .o_done      (done),
        .i_ack       (ack)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural array: A moves right, B moves down, one register per hop; enable low clears.
    int acc [N][N];
    int pa  [N][N];
    int pb  [N][N];
    int na  [N][N];
    int nb  [N][N];
    logic saw_rdy = 1'b0;

    always @(negedge clk) begin
        if (vif.o_ready) saw_rdy = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int ain, bin;
                ain = (c == 0) ? int'(a_lane[r*W +: W]) : pa[r][c-1];
                bin = (r == 0) ? int'(b_lane[c*W +: W]) : pb[r-1][c];
                if (do_proc) begin
                    acc[r][c] = acc[r][c] + ain * bin;
                    na[r][c]  = ain;
                    nb[r][c]  = bin;
                end else begin
                    acc[r][c] = 0;
                    na[r][c]  = 0;
                    nb[r][c]  = 0;
                end
            end
        end
        pa = na;
        pb = nb;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [KW-1:0] kk);
        start = 1'b1;
        k_len = kk;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        chk(tag, vif.o_ready, 1'b1);
        vif.i_valid = 1'b1;
        vif.i_a_vec = a;
        vif.i_b_vec = b;
        tick();
        vif.i_valid = 1'b0;
        vif.i_a_vec = '0;
        vif.i_b_vec = '0;
    endtask

    // Cycles counted from the last accept cycle L; returns the offset at which o_done is seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_c(input string tag, input int mul);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk(tag, acc[r][c], mul * (r + 1) * (c + 1));
    endtask

    task automatic ack_job;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] v1234, sa, sb, ea, eb;
        int lat, bad, sum;
        v1234 = 32'h04030201;
        vif.i_valid = 1'b0;
        vif.i_a_vec = '0;
        vif.i_b_vec = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_doproc", do_proc, 1'b0);
        chk("rst_ready", vif.o_ready, 1'b0);
        chk("rst_lanes", {a_lane, b_lane}, 64'h0);
        arst_n = 1'b1;
        tick();

        // k=3, back-to-back beats
        start_job(16'd3);
        chk("k3_busy", busy, 1'b1);
        send("k3_rdy0", v1234, v1234);
        send("k3_rdy1", v1234, v1234);
        send("k3_rdy2", v1234, v1234);
        chk("k3_rdy_end", vif.o_ready, 1'b0);
        wait_done(1, lat);
        chk("k3_done_lat", lat, 8);
        check_c("k3_c", 3);

        // Hold in DONE without ack
        bad = 0;
        repeat (20) begin
            tick();
            if (!do_proc || !done || a_lane != '0 || b_lane != '0) bad++;
        end
        chk("hold_bad", bad, 0);
        chk("hold_c33", acc[3][3], 48);
        // Ack together with start: ack only
        ack = 1'b1;
        start = 1'b1;
        k_len = 16'd5;
        tick();
        ack = 1'b0;
        start = 1'b0;
        chk("ack_doproc", do_proc, 1'b0);
        chk("ack_busy", busy, 1'b0);
        tick();
        chk("ack_start_ign", busy, 1'b0);
        chk("ack_clear", acc[3][3], 0);

        // k=2 with one valid gap
        start_job(16'd2);
        send("gap_rdy0", v1234, v1234);
        chk("gap_rdy_idle", vif.o_ready, 1'b1);
        tick();
        send("gap_rdy1", v1234, v1234);
        wait_done(1, lat);
        chk("gap_done_lat", lat, 8);
        check_c("gap_c", 2);
`ifdef FEEDER_STALL_CNT_EN
        chk("gap_stall_cnt", stall_cnt, 16'd1);
`endif
        ack_job();
        tick();

        // Single-beat skew check
        sa = 32'h44332211;
        sb = 32'h88776655;
        start_job(16'd1);
        send("skew_rdy", sa, sb);
        for (int t = 1; t <= N + 1; t++) begin
            ea = (t <= N) ? (sa & (32'hFF << (8 * (t - 1)))) : '0;
            eb = (t <= N) ? (sb & (32'hFF << (8 * (t - 1)))) : '0;
            chk($sformatf("skew_a_t%0d", t), a_lane, ea);
            chk($sformatf("skew_b_t%0d", t), b_lane, eb);
            tick();
        end
        wait_done(N + 2, lat);
        chk("skew_done_lat", lat, 8);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                chk("skew_c", acc[r][c], ((r + 1) * 17) * ((c + 5) * 17));
        ack_job();
        tick();

        // k=0: straight to drain
        saw_rdy = 1'b0;
        start_job(16'd0);
        chk("k0_busy", busy, 1'b1);
        wait_done(1, lat);
        chk("k0_done_lat", lat, 8);
        chk("k0_never_rdy", saw_rdy, 1'b0);
        sum = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                sum += acc[r][c];
        chk("k0_c_zero", sum, 0);
        ack_job();
        tick();

        // Reset mid-stream
        start_job(16'd3);
        send("rstm_rdy", v1234, v1234);
        #2;
        arst_n = 1'b0;
        tick();
        chk("rstm_busy", busy, 1'b0);
        chk("rstm_doproc", do_proc, 1'b0);
        chk("rstm_ready", vif.o_ready, 1'b0);
        chk("rstm_done", done, 1'b0);
        chk("rstm_lanes", {a_lane, b_lane}, 64'h0);
`ifdef FEEDER_STALL_CNT_EN
        chk("rstm_stall_cnt", stall_cnt, 16'd0);
`endif
        arst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
